// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: move/arith/logic in one RUN cycle, iterative shifts/RLC and shift-add MUL.
// Start sampled only in IDLE (no queuing); MULTICYCLE_ALU_FAST_SHIFT_EN selects a one-cycle barrel shifter.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       FunSel,
  input  logic             WF,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   ShAmt,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_LSL = 4'b1011;
  localparam logic [3:0] OP_LSR = 4'b1100;
  localparam logic [3:0] OP_ASR = 4'b1101;
  localparam logic [3:0] OP_RLC = 4'b1110;
  localparam logic [3:0] OP_MUL = 4'b1111;
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic             wf_q, cin_q;
  logic [WIDTH-1:0] a_q, b_q, work_q;
  logic [SHW:0]     cnt_q;
  logic             last_step;

  logic [WIDTH-1:0] res_d, work_d, b_d, add_b;
  logic             c_d, c_upd, o_d, o_upd, cin_d, add_ci;
  logic [WIDTH:0]   sum, mul_sum;

`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
  localparam logic [SHW:0] RING_W = (SHW+1)'(WIDTH + 1);
  logic [SHW-1:0] sh_q;
  logic [WIDTH:0] lsl_w, lsr_w, asr_w, ring, rot;

  // One extra bit on each shift catches the last bit shifted out.
  assign lsl_w = {1'b0, a_q} << sh_q;
  assign lsr_w = {a_q, 1'b0} >> sh_q;
  assign asr_w = $signed({a_q, 1'b0}) >>> sh_q;
  assign ring  = {cin_q, a_q};
  assign rot   = (ring << sh_q) | (ring >> (RING_W - {1'b0, sh_q}));
`else
  logic zero_sh_q;
`endif

  assign add_b   = (op_q == OP_SUB) ? ~b_q : b_q;
  assign add_ci  = (op_q == OP_SUB) | ((op_q == OP_ADC) & cin_q);
  assign sum     = {1'b0, a_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
  // Product lives in {work_q, b_q}: accumulate into the high half, shift both right.
  assign mul_sum = {1'b0, work_q} + (b_q[0] ? {1'b0, a_q} : '0);

  assign last_step = (state_q == RUN) && (cnt_q == CNT_ONE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      IDLE: if (Start) state_d = RUN;
      RUN: begin
        Busy = 1'b1;
        if (cnt_q == CNT_ONE) state_d = DONE;
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_d  = '0;
    work_d = work_q;
    b_d    = b_q;
    cin_d  = cin_q;
    c_d    = 1'b0;
    c_upd  = 1'b0;
    o_d    = 1'b0;
    o_upd  = 1'b0;
    case (op_q)
      4'b0000: res_d = a_q;
      4'b0001: res_d = b_q;
      4'b0010: res_d = ~a_q;
      4'b0011: res_d = ~b_q;
      OP_ADD, OP_ADC: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        c_upd = 1'b1;
        o_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        o_upd = 1'b1;
      end
      OP_SUB: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        c_upd = 1'b1;
        o_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        o_upd = 1'b1;
      end
      4'b0111: res_d = a_q & b_q;
      4'b1000: res_d = a_q | b_q;
      4'b1001: res_d = a_q ^ b_q;
      4'b1010: res_d = ~(a_q & b_q);
      OP_LSL, OP_LSR, OP_ASR, OP_RLC: begin
`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
        case (op_q)
          OP_LSL:  begin res_d = lsl_w[WIDTH-1:0]; c_d = lsl_w[WIDTH]; end
          OP_LSR:  begin res_d = lsr_w[WIDTH:1];   c_d = lsr_w[0];     end
          OP_ASR:  begin res_d = asr_w[WIDTH:1];   c_d = asr_w[0];     end
          default: begin res_d = rot[WIDTH-1:0];   c_d = rot[WIDTH];   end
        endcase
        c_upd = (sh_q != '0);
`else
        case (op_q)
          OP_LSL:  begin work_d = {work_q[WIDTH-2:0], 1'b0};         c_d = work_q[WIDTH-1]; end
          OP_LSR:  begin work_d = {1'b0, work_q[WIDTH-1:1]};         c_d = work_q[0];       end
          OP_ASR:  begin work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; c_d = work_q[0];    end
          default: begin work_d = {work_q[WIDTH-2:0], cin_q};        c_d = work_q[WIDTH-1]; end
        endcase
        // cin_q doubles as the running ring bit for RLC.
        if (zero_sh_q) work_d = work_q;
        else           cin_d  = c_d;
        res_d = work_d;
        c_upd = !zero_sh_q;
`endif
      end
      default: begin
        work_d = mul_sum[WIDTH:1];
        b_d    = {mul_sum[0], b_q[WIDTH-1:1]};
        res_d  = b_d;
        c_d    = |work_d;
        c_upd  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_q      <= '0;
      wf_q      <= 1'b0;
      cin_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      ALUOut    <= '0;
      FlagsOut  <= '0;
`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
      sh_q      <= '0;
`else
      zero_sh_q <= 1'b0;
`endif
    end else if (state_q == IDLE && Start) begin
      op_q   <= FunSel;
      wf_q   <= WF;
      cin_q  <= FlagsOut[1];
      a_q    <= A;
      b_q    <= B;
      work_q <= (FunSel == OP_MUL) ? '0 : A;
      if (FunSel == OP_MUL)
        cnt_q <= (SHW+1)'(WIDTH);
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
      else if (FunSel >= OP_LSL && FunSel <= OP_RLC && ShAmt != '0)
        cnt_q <= {1'b0, ShAmt};
`endif
      else
        cnt_q <= CNT_ONE;
`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
      sh_q      <= ShAmt;
`else
      zero_sh_q <= (ShAmt == '0);
`endif
    end else if (state_q == RUN) begin
      cnt_q  <= cnt_q - CNT_ONE;
      work_q <= work_d;
      b_q    <= b_d;
      cin_q  <= cin_d;
      if (last_step) begin
        ALUOut <= res_d;
        if (wf_q) begin
          FlagsOut[0] <= (res_d == '0);
          FlagsOut[2] <= res_d[WIDTH-1];
          if (c_upd) FlagsOut[1] <= c_d;
          if (o_upd) FlagsOut[3] <= o_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu at WIDTH=16: directed cases with fixed answers, then random ops
// scored against an arithmetic reference model that also tracks the flag register.
module tb_multicycle_alu;
  localparam int W  = 16;
  localparam int SW = 4;
`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
  localparam int ASR3_LAT = 2;
`else
  localparam int ASR3_LAT = 4;
`endif

  logic          Clock = 1'b0;
  logic          Reset, Start, WF;
  logic [3:0]    FunSel;
  logic [W-1:0]  A, B, ALUOut;
  logic [SW-1:0] ShAmt;
  logic [3:0]    FlagsOut;
  logic          Busy, Done;

  int checks = 0;
  int errors = 0;
  logic [3:0] mfl;

  multicycle_alu #(.WIDTH(W), .SHW(SW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .FunSel(FunSel), .WF(WF),
    .A(A), .B(B), .ShAmt(ShAmt), .ALUOut(ALUOut), .FlagsOut(FlagsOut),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: result, flags and latency straight from the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] sh, input logic wf, inout logic [3:0] fl,
                                output logic [15:0] r, output int lat);
    int sa, sb, sr, ci, c, o;
    logic [31:0] p;
    logic [16:0] ring;
    c = -1; o = -1; lat = 2; r = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      4'h0: r = a;
      4'h1: r = b;
      4'h2: r = ~a;
      4'h3: r = ~b;
      4'h4, 4'h5: begin
        ci = (op == 4'h5) ? int'(fl[1]) : 0;
        sr = int'(a) + int'(b) + ci;
        r  = 16'(sr);
        c  = int'(sr > 65535);
        o  = int'((sa + sb + ci) > 32767 || (sa + sb + ci) < -32768);
      end
      4'h6: begin
        r = a - b;
        c = int'(a >= b);
        o = int'((sa - sb) > 32767 || (sa - sb) < -32768);
      end
      4'h7: r = a & b;
      4'h8: r = a | b;
      4'h9: r = a ^ b;
      4'hA: r = ~(a & b);
      4'hB: begin
        p = 32'(a) << sh;
        r = p[15:0];
        if (sh != 0) c = int'(p[16]);
      end
      4'hC: begin
        r = a >> sh;
        if (sh != 0) c = int'(a[sh-1]);
      end
      4'hD: begin
        r = 16'($signed(a) >>> sh);
        if (sh != 0) c = int'(a[sh-1]);
      end
      4'hE: begin
        ring = {fl[1], a};
        for (int i = 0; i < int'(sh); i++) ring = {ring[15:0], ring[16]};
        r = ring[15:0];
        if (sh != 0) c = int'(ring[16]);
      end
      default: begin
        p   = 32'(a) * 32'(b);
        r   = p[15:0];
        c   = int'(p[31:16] != 0);
        lat = 17;
      end
    endcase
    if (op >= 4'hB && op <= 4'hE) begin
`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
      lat = 2;
`else
      lat = 1 + ((sh == 0) ? 1 : int'(sh));
`endif
    end
    if (wf) begin
      fl[0] = (r == 16'h0);
      fl[2] = r[15];
      if (c >= 0) fl[1] = c[0];
      if (o >= 0) fl[3] = o[0];
    end
  endfunction

  // Launch one op; optionally pulse Start again poke_at cycles in (must be ignored).
  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sh, input logic wf, input int poke_at,
                       output logic [15:0] res, output logic [3:0] fl, output int lat);
    @(negedge Clock);
    Start = 1'b1; FunSel = op; A = a; B = b; ShAmt = sh; WF = wf;
    @(posedge Clock); #1;
    Start = 1'b0;
    FunSel = 4'($urandom); A = 16'($urandom); B = 16'($urandom);
    ShAmt = 4'($urandom); WF = 1'($urandom);
    lat = 1;
    chk("busy_after_start", 32'(Busy), 32'd1);
    while (Done !== 1'b1 && lat < 60) begin
      if (lat == poke_at) Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0;
      lat++;
    end
    chk("done_seen", 32'(Done), 32'd1);
    chk("busy_in_done", 32'(Busy), 32'd0);
    res = ALUOut;
    fl  = FlagsOut;
    @(posedge Clock); #1;
    chk("done_pulse", 32'(Done), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] sh, input logic wf,
                          input logic [15:0] exp_r, input logic [3:0] exp_fl,
                          input int exp_lat, input int poke);
    logic [15:0] mr, r;
    logic [3:0]  fl;
    int ml, lat;
    model(op, a, b, sh, wf, mfl, mr, ml);
    do_op(op, a, b, sh, wf, poke, r, fl, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, 32'(r), 32'(exp_r));
    chk({tag, "_flags"}, 32'(fl), 32'(exp_fl));
  endtask

  initial begin
    logic [15:0] r, mr, ra, rb;
    logic [3:0]  fl, op, sh;
    logic        wf;
    int lat, ml, ndone;

    Reset = 1'b0; Start = 1'b0; FunSel = '0; WF = 1'b0; A = '0; B = '0; ShAmt = '0;
    mfl = 4'h0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_aluout", 32'(ALUOut), 32'd0);
    chk("rst_flags", 32'(FlagsOut), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    directed("add_ovf", 4'h4, 16'h7FFF, 16'h0001, 4'd0, 1'b1, 16'h8000, 4'hC, 2, 0);
    directed("sub_borrow", 4'h6, 16'h0003, 16'h0005, 4'd0, 1'b1, 16'hFFFE, 4'h4, 2, 0);
    directed("sub_nowf", 4'h6, 16'h0007, 16'h0002, 4'd0, 1'b0, 16'h0005, 4'h4, 2, 0);

    // Abort a MUL five cycles in.
    @(negedge Clock);
    Start = 1'b1; FunSel = 4'hF; A = 16'h1234; B = 16'h5678; WF = 1'b1; ShAmt = '0;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    chk("abort_busy_before", 32'(Busy), 32'd1);
    Reset = 1'b0;
    #1;
    chk("abort_aluout", 32'(ALUOut), 32'd0);
    chk("abort_flags", 32'(FlagsOut), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    mfl = 4'h0;
    ndone = 0;
    repeat (20) begin
      @(posedge Clock); #1;
      if (Done === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    directed("asr3", 4'hD, 16'h8004, 16'h0000, 4'd3, 1'b1, 16'hF000, 4'h6, ASR3_LAT, 0);
    directed("add_clrc", 4'h4, 16'h0001, 16'h0001, 4'd0, 1'b1, 16'h0002, 4'h0, 2, 0);
    directed("rlc1", 4'hE, 16'h8001, 16'h0000, 4'd1, 1'b1, 16'h0002, 4'h2, 2, 0);
    directed("rlc0", 4'hE, 16'h8001, 16'h0000, 4'd0, 1'b1, 16'h8001, 4'h6, 2, 0);
    directed("mul", 4'hF, 16'h0100, 16'h0100, 4'd0, 1'b1, 16'h0000, 4'h3, 17, 5);
    ndone = 0;
    repeat (20) begin
      @(posedge Clock); #1;
      if (Done === 1'b1) ndone++;
    end
    chk("mul_no_extra_done", 32'(ndone), 32'd0);

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      sh = 4'($urandom);
      wf = ($urandom_range(3) != 0);
      case ($urandom_range(7))
        0: ra = 16'h8000;
        1: rb = ~ra;
        2: rb = ra;
        default: ;
      endcase
      model(op, ra, rb, sh, wf, mfl, mr, ml);
      do_op(op, ra, rb, sh, wf, 0, r, fl, lat);
      chk($sformatf("rnd%0d_op%0h_lat", i, op), 32'(lat), 32'(ml));
      chk($sformatf("rnd%0d_op%0h_res", i, op), 32'(r), 32'(mr));
      chk($sformatf("rnd%0d_op%0h_flags", i, op), 32'(fl), 32'(mfl));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
